// File: rtl/multiplier_seq.sv
// Sequential radix-2 shift-add multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n (async low); in_valid/in_ready with A, B operands;
//        out_valid/out_ready with P = A*B; busy high in CALC or DONE.
// Option: define MULT_EARLY_TERM_EN to leave CALC once the multiplier
//         register has shifted down to zero.
module multiplier_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] P,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [PW-1:0]     p_q, p_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              last;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      p_d       = p_q;
      last      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               acc_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, A};
               mplier_d = B;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
`ifdef MULT_EARLY_TERM_EN
            // no set bits left: the remaining steps add nothing
            last = (mplier_d == '0) ||
                   (cnt_q == LAST_CNT);
`else
            last = (cnt_q == LAST_CNT);
`endif
            if (last) begin
               // P only moves here, so it holds through IDLE/CALC
               p_d     = acc_d;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
      end
   end

   assign P = p_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Scoreboard bench for multiplier_seq: an 8-bit and a 2-bit instance.
// Stimulus pushes expected product/latency; a negedge monitor checks.
module tb_multiplier_seq;

   typedef struct {
      logic [15:0] p;
      int          lat;
   } item_t;

   logic        clk;
   logic        rst_n;
   logic        iv8, ir8, ov8, or8, bz8;
   logic [7:0]  A8, B8;
   logic [15:0] P8;
   logic        iv2, ir2, ov2, or2, bz2;
   logic [1:0]  A2, B2;
   logic [3:0]  P2;

   item_t       sbq[2][$];
   logic        pov[2];
   logic [15:0] pp[2];
   int          acyc[2];
   int          cyc;
   int          total;
   int          bad;
   bit          rnd;

   multiplier_seq #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv8), .in_ready(ir8),
      .A(A8), .B(B8),
      .out_valid(ov8), .out_ready(or8),
      .P(P8), .busy(bz8)
   );

   multiplier_seq #(.WIDTH(2)) u2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv2), .in_ready(ir2),
      .A(A2), .B(B2),
      .out_valid(ov2), .out_ready(or2),
      .P(P2), .busy(bz2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rnd) or8 = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string nm,
                      input int act,
                      input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input int w,
                                 input logic [7:0] b);
      int n;
`ifdef MULT_EARLY_TERM_EN
      n = 1;
      for (int i = 0; i < w; i++)
         if (b[i]) n = i + 1;
`else
      n = w;
`endif
      return n;
   endfunction

   task automatic mon(input int d,
                      input logic ov, input logic orr,
                      input logic iv, input logic ir,
                      input logic bz,
                      input logic [15:0] p);
      item_t it;
      chk($sformatf("busy%0d", d), int'(bz), int'(!ir));
      if (ov && !pov[d]) begin
         chk($sformatf("pending%0d", d),
             int'(sbq[d].size() != 0), 1);
         if (sbq[d].size() != 0)
            chk($sformatf("lat%0d", d),
                cyc - acyc[d], sbq[d][0].lat);
      end
      if (ov && pov[d])
         chk($sformatf("hold%0d", d), int'(p), int'(pp[d]));
      if (ov && orr && sbq[d].size() != 0) begin
         it = sbq[d].pop_front();
         chk($sformatf("prod%0d", d), int'(p), int'(it.p));
      end
      if (iv && ir) acyc[d] = cyc + 1;
      pov[d] = ov;
      pp[d]  = p;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, ov8, or8, iv8, ir8, bz8, P8);
         mon(1, ov2, or2, iv2, ir2, bz2, {12'b0, P2});
      end else begin
         pov[0] = 1'b0;
         pov[1] = 1'b0;
      end
   end

   task automatic issue(input int d,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [15:0] exp,
                        input int lat,
                        input bit keep);
      item_t it;
      bit    ok;
      int    n;
      it.p   = exp;
      it.lat = lat;
      sbq[d].push_back(it);
      if (d == 0) begin
         A8 = a; B8 = b; iv8 = 1'b1;
      end else begin
         A2 = a[1:0]; B2 = b[1:0]; iv2 = 1'b1;
      end
      n = 0;
      do begin
         ok = (d == 0) ? ir8 : ir2;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 200);
      chk("accept", int'(ok), 1);
      if (!keep) begin
         if (d == 0) iv8 = 1'b0;
         else iv2 = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq[0].size() + sbq[1].size() != 0 ||
              ov8 || ov2) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", sbq[0].size() + sbq[1].size(), 0);
   endtask

   logic [7:0] ta[5] = '{8'd255, 8'd0, 8'd200, 8'd5, 8'd1};
   logic [7:0] tb[5] = '{8'd255, 8'd200, 8'd0, 8'd3, 8'd128};
   logic [15:0] tp[5] = '{16'd65025, 16'd0, 16'd0, 16'd15, 16'd128};

   initial begin
      int n;
      logic [7:0] a, b;
      total = 0; bad = 0; rnd = 1'b0;
      pov[0] = 1'b0; pov[1] = 1'b0;
      pp[0] = '0; pp[1] = '0;
      acyc[0] = 0; acyc[1] = 0;
      rst_n = 1'b0;
      iv8 = 1'b0; iv2 = 1'b0;
      or8 = 1'b1; or2 = 1'b1;
      A8 = '0; B8 = '0; A2 = '0; B2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ir8", int'(ir8), 1);
      chk("rst ov8", int'(ov8), 0);
      chk("rst bz8", int'(bz8), 0);
      chk("rst P8", int'(P8), 0);
      chk("rst ir2", int'(ir2), 1);
      chk("rst P2", int'(P2), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            issue(1, 8'(i), 8'(j),
                  16'(i * j), lat_of(2, 8'(j)), 1'b1);
      iv2 = 1'b0;

      for (int i = 0; i < 5; i++)
         issue(0, ta[i], tb[i], tp[i],
               lat_of(8, tb[i]), 1'b0);
      drain();

      or8 = 1'b0;
      issue(0, 8'd12, 8'd11, 16'd132,
            lat_of(8, 8'd11), 1'b0);
      n = 0;
      while (!ov8 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("held valid", int'(ov8), 1);
      repeat (5) begin
         A8 = 8'($urandom);
         B8 = 8'($urandom);
         iv8 = 1'b1;
         chk("held ir", int'(ir8), 0);
         chk("held P", int'(P8), 132);
         @(posedge clk); #1;
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      @(posedge clk); #1;
      chk("ready back", int'(ir8), 1);
      chk("valid gone", int'(ov8), 0);
      drain();

      issue(0, 8'd7, 8'd9, 16'd63,
            lat_of(8, 8'd9), 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("abort ir", int'(ir8), 1);
      chk("abort P", int'(P8), 0);
      chk("abort bz", int'(bz8), 0);
      chk("abort ov", int'(ov8), 0);
      sbq[0].delete();
      @(posedge clk); #3;
      rst_n = 1'b1;

      rnd = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         if (i == 0) begin
            a = 8'd7; b = 8'd9;
         end
         issue(0, a, b, 16'(a) * 16'(b),
               lat_of(8, b), 1'b1);
      end
      iv8 = 1'b0;
      drain();
      rnd = 1'b0;
      @(posedge clk); #2;
      or8 = 1'b1;

      repeat (12) @(posedge clk);
      #1;
      chk("idle ov", int'(ov8), 0);
      chk("idle bz", int'(bz8), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
